// File: rtl/i2c_param_fifo_if.sv
// rtl/i2c_param_fifo_if.sv - FIFO access and status bundle
interface i2c_param_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int A = $clog2(DEPTH);

    logic                  clear;
    logic                  w_enable;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_enable;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [A:0]            count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, w_enable, w_data, r_enable,
        input  r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clear, w_enable, w_data, r_enable,
        output r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/i2c_param_fifo.sv
// rtl/i2c_param_fifo.sv - parametrised first-word-fall-through byte FIFO
module i2c_param_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                w_clk,
    input  logic                n_rst,
    i2c_param_fifo_if.slave     bus
);
    localparam int         A     = $clog2(DEPTH);
    localparam logic [A:0] L_ONE = {{A{1'b0}}, 1'b1};
    localparam logic [A:0] L_AF  = (A+1)'(AF_LEVEL);
    localparam logic [A:0] L_AE  = (A+1)'(AE_LEVEL);

    logic [A:0]            r_wr_ptr;
    logic [A:0]            r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [A:0]            w_count;

    // Extra wrap bit on each pointer distinguishes full from empty when low bits match.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[A] != r_rd_ptr[A]) && (r_wr_ptr[A-1:0] == r_rd_ptr[A-1:0]);
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_wr_acc = bus.w_enable && !w_full && !bus.clear;
    assign w_rd_acc = bus.r_enable && !w_empty && !bus.clear;

    always_ff @(posedge w_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + L_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + L_ONE;
            end
            if (bus.w_enable && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.r_enable && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[A-1:0]] <= bus.w_data;
        end
    end

    assign bus.r_data       = w_empty ? '0 : r_mem[r_rd_ptr[A-1:0]];
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.count        = w_count;
    assign bus.almost_full  = (w_count >= L_AF);
    assign bus.almost_empty = (w_count <= L_AE);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: doc/i2c_param_fifo.md
# i2c_param_fifo

Parametrised synchronous FIFO for the I2C controller's TX and RX byte queues, replacing the fixed 8x8 buffer. One instance sits between the APB register block and the byte-level shifter in each direction. It adds configurable width and depth, correct full/empty detection across pointer wrap, an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per entry
- DEPTH, 8, number of entries; power of two, minimum 2
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1

Ports (A = $clog2(DEPTH)):
- w_clk  input  1  single clock for both read and write sides
- n_rst  input  1  asynchronous, active-low reset
- clear  input  1  synchronous flush
- w_enable  input  1  write request
- w_data  input  DATA_WIDTH  write data
- r_enable  input  1  read (pop) request
- r_data  output  DATA_WIDTH  head-of-queue data, first-word-fall-through
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  A+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x DATA_WIDTH register array, no reset on contents.
- Pointers: wr_ptr and rd_ptr, each A+1 bits. Low A bits index the array. The MSB is a wrap bit. Each pointer increments by 1 mod 2^(A+1) on an accepted access.
- Flag derivation: empty when pointers are equal; full when MSBs differ and low bits are equal. count = wr_ptr - rd_ptr, computed in A+1 bits.
- Write accepted: w_enable && !full && !clear. w_data is stored at wr_ptr[A-1:0].
- Read accepted: r_enable && !empty && !clear. rd_ptr advances; the entry is discarded.
- Simultaneous write and read, neither blocked: both are accepted and count is unchanged.
- Simultaneous write and read when full: the read is accepted. The write is rejected and sets overflow.
- Simultaneous write and read when empty: the write is accepted. The read is rejected and sets underflow.
- overflow and underflow are sticky. They clear only on clear or reset.
- clear: on the next edge, both pointers go to 0 and both error flags go to 0. clear overrides w_enable and r_enable in the same cycle; neither access is performed and no error flag is set.
- r_data = array[rd_ptr[A-1:0]] when !empty, otherwise all zeros.

## Timing
- Reset (n_rst low, asynchronous): pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, r_data 0.
- Clocked state: all state updates on posedge w_clk.
- Status outputs: full, empty, count, almost_* are combinational from the registered pointers. They reflect an access on the edge that performs it.
- Write latency: a write accepted at edge N makes the data visible on r_data after edge N when the FIFO was empty; empty deasserts after edge N.
- Read latency: zero. r_data is valid whenever empty is 0. A pop at edge N presents the next entry after edge N.
- Throughput: one write and one read per cycle sustained, with no bubbles at wrap-around.
- Error flag latency: overflow/underflow assert after the edge at which the rejected request was sampled.

## Test plan
- Reset then idle: all outputs at reset values; r_data = 0x00 and count = 0 for 5 cycles.
- Fill/drain ordering (DEPTH=8): write 0x11..0x88 on consecutive cycles. Required: full = 1 and almost_full = 1 after the 8th edge, count = 8. Then pop 8 times; r_data sequence 0x11..0x88, empty = 1 at the end.
- Wrap-around: write 5 entries, read 5, then write 8 entries (0xA0..0xA7) and read all 8. Required: data in order, full asserts exactly at count 8, no spurious empty.
- Overflow: with the FIFO full, assert w_enable with 0xFF for one cycle. Required: overflow = 1, count stays 8, 0xFF never appears on r_data. Then pulse clear: overflow = 0, empty = 1.
- Underflow and simultaneous access on empty: with the FIFO empty, assert r_enable and w_enable with 0x5A. Required: count = 1, r_data = 0x5A, underflow = 1.
- Simultaneous at full plus clear priority: with the FIFO full, assert both enables. Required: count 8 → 7, overflow = 1. Then assert clear with both enables for one cycle. Required: count = 0, flags cleared, no write performed.
